i_cache_refill_ctrl: RTL
========================

I_CACHE_REFILL_CTRL -- requirements
Module: i_cache_refill_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 64, fetch/memory address width.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_valid_i  in  1  fetch request valid.
- if_addr_i  in  ADDR_W  fetch byte address (bits [1:0] ignored).
- if_ready_o  out  1  request accepted when high with if_valid_i.
- inst_valid_o  out  1  one-cycle pulse, instruction valid.
- inst_o  out  32  fetched instruction.
- fence_i_i  in  1  invalidate all lines.
- ram_addr_o  out  6  data RAM word address {index,offset}.
- ram_data_o  out  32  data RAM write data.
- ram_we_o  out  1  data RAM write enable.
- ram_data_i  in  32  data RAM read data, one cycle after address.
- mem_req_o  out  1  line read request.
- mem_addr_o  out  ADDR_W  line-aligned request address.
- mem_gnt_i  in  1  request granted.
- mem_rvalid_i  in  1  refill beat valid.
- mem_rdata_i  in  32  refill beat data.

Function
REQ-003 SHALL implement a direct-mapped cache: 16 lines x 4 words; offset = addr[3:2], index = addr[7:4], tag = addr[ADDR_W-1:8].
REQ-004 SHALL use FSM states IDLE, LOOKUP, MISS_REQ, REFILL, REPLAY.
REQ-005 if_ready_o SHALL be high only in IDLE with no pending fence; handshake = if_valid_i & if_ready_o.
REQ-006 In IDLE, ram_addr_o SHALL equal {if_addr_i[7:4], if_addr_i[3:2]} combinationally; on handshake, address SHALL be registered and FSM -> LOOKUP.
REQ-007 LOOKUP hit (valid[index] & tag match): inst_valid_o=1, inst_o=ram_data_i in that cycle, FSM -> IDLE; hit latency = 1 cycle after handshake.
REQ-008 LOOKUP miss: FSM -> MISS_REQ; mem_req_o=1 and mem_addr_o={tag,index,4'b0} held until mem_gnt_i, then FSM -> REFILL with beat counter = 0.
REQ-009 REFILL: each mem_rvalid_i SHALL drive ram_we_o=1, ram_addr_o={index,cnt}, ram_data_o=mem_rdata_i, then increment 2-bit cnt; beats without mem_rvalid_i SHALL write nothing.
REQ-010 On 4th beat: tag[index] and valid[index] SHALL update at the same edge; FSM -> REPLAY.
REQ-011 REPLAY SHALL drive ram_addr_o={index,offset} for one cycle, then FSM -> LOOKUP (guaranteed hit).
REQ-012 ram_we_o SHALL be 0 outside REFILL; mem_req_o SHALL be 0 outside MISS_REQ.
REQ-013 fence_i_i asserted in any state SHALL set a pending flag; flag SHALL be serviced in IDLE by clearing all valid bits in one cycle (if_ready_o=0 that cycle), never mid-refill.
REQ-014 An in-flight request SHALL complete with the line refilled before a pending fence takes effect.
REQ-015 inst_o SHALL be don't-care when inst_valid_o=0.

Reset
REQ-016 On rst: FSM=IDLE, all valid bits=0, cnt=0, fence flag=0; inst_valid_o, ram_we_o, mem_req_o = 0 at next edge.
REQ-017 Reset mid-REFILL SHALL abandon the line (valid stays 0); subsequent mem_rvalid_i SHALL be ignored in IDLE.

Structure
REQ-018 Package SHALL hold LINE_WORDS=4, OFFSET_W=2, INDEX_W=4, line count, and the FSM state enum.
REQ-019 Tag+valid storage SHALL be a sub-module i_cache_tag_array (16 entries, write port, combinational read, clear-all input); the data RAM is external.

Verification
REQ-020 Bench SHALL cover:
- Cold miss 0x8000_0004: mem_addr_o=0x8000_0000, beats 0x11,0x22,0x33,0x44 written to RAM addrs 0..3; inst_o=0x22.
- Hit after fill: fetch 0x8000_000C -> inst_valid_o one cycle after handshake, inst_o=0x44, no mem_req_o.
- Conflict: fetch 0x8000_0100 (same index 0, new tag) -> refill, then 0x8000_0000 misses again.
- Gapped beats (rvalid low 3 cycles between beats) -> exactly 4 writes, correct data.
- fence_i_i during REFILL -> request completes, then all lines invalid; next fetch 0x8000_0004 misses.
- rst in REFILL after 2 beats -> mem_req_o=0, if_ready_o=1 next cycle, line 0 invalid.

Source files
------------

// File: rtl/i_cache_refill_ctrl_pkg.sv
// Shared geometry and FSM encoding for the instruction-cache refill controller.
// 16 direct-mapped lines of 4 x 32-bit words.
package i_cache_refill_ctrl_pkg;

  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 2;
  localparam int INDEX_W    = 4;
  localparam int NUM_LINES  = 16;
  localparam int BYTE_OFS_W = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MISS_REQ = 3'd2,
    REFILL   = 3'd3,
    REPLAY   = 3'd4
  } state_t;

endpackage

// File: rtl/i_cache_refill_ctrl_tag.sv
// Tag + valid storage for the direct-mapped instruction cache.
// Combinational read port, single write port, single-cycle clear of every valid bit.
module i_cache_tag_array
  import i_cache_refill_ctrl_pkg::*;
#(
  parameter int TAG_W = 56
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_all,
  input  logic               we,
  input  logic [INDEX_W-1:0] windex,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [INDEX_W-1:0] rindex,
  output logic [TAG_W-1:0]   rtag,
  output logic               rvalid
);

  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [NUM_LINES-1:0] valid;

  // Valid bits: cleared by reset or fence, set when a line finishes refilling.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (we) begin
      valid[windex] <= 1'b1;
    end
  end

  // Tag storage needs no reset; a tag is only trusted behind its valid bit.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      tags[windex] <= wtag;
    end
  end

  assign rtag   = tags[rindex];
  assign rvalid = valid[rindex];

endmodule

// File: rtl/i_cache_refill_ctrl.sv
// Instruction-cache lookup/refill controller: hit check against the tag array,
// line refill from memory into the external data RAM, replay, and fence.i invalidation.
module i_cache_refill_ctrl
  import i_cache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  input  logic              fence_i_i,
  output logic [5:0]        ram_addr_o,
  output logic [31:0]       ram_data_o,
  output logic              ram_we_o,
  input  logic [31:0]       ram_data_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int WORD_W = ADDR_W - BYTE_OFS_W;
  localparam int TAG_W  = WORD_W - OFFSET_W - INDEX_W;

  state_t state;
  state_t next_state;

  logic [WORD_W-1:0]   req_word;
  logic [OFFSET_W-1:0] req_offset;
  logic [INDEX_W-1:0]  req_index;
  logic [TAG_W-1:0]    req_tag;
  logic [OFFSET_W-1:0] cnt;
  logic                fence_pending;
  logic                handshake;
  logic                fence_clear;
  logic                fill_done;
  logic                hit;
  logic [TAG_W-1:0]    lu_tag;
  logic                lu_valid;
  logic                unused_addr_bits;

  assign req_offset = req_word[OFFSET_W-1:0];
  assign req_index  = req_word[OFFSET_W +: INDEX_W];
  assign req_tag    = req_word[WORD_W-1 -: TAG_W];

  assign handshake   = if_valid_i & if_ready_o;
  assign fence_clear = (state == IDLE) & fence_pending;
  assign fill_done   = (state == REFILL) & mem_rvalid_i & (cnt == OFFSET_W'(LINE_WORDS - 1));
  assign hit         = lu_valid & (lu_tag == req_tag);

  assign mem_addr_o       = {req_tag, req_index, 4'b0000};
  assign ram_data_o       = mem_rdata_i;
  assign unused_addr_bits = ^if_addr_i[BYTE_OFS_W-1:0];

  i_cache_tag_array #(
    .TAG_W(TAG_W)
  ) u_tag_array (
    .clk      (clk),
    .rst      (rst),
    .clear_all(fence_clear),
    .we       (fill_done),
    .windex   (req_index),
    .wtag     (req_tag),
    .rindex   (req_index),
    .rtag     (lu_tag),
    .rvalid   (lu_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request address, beat counter and fence flag; a new fence request wins over servicing.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_word      <= '0;
      cnt           <= '0;
      fence_pending <= 1'b0;
    end else begin
      if (handshake) begin
        req_word <= if_addr_i[ADDR_W-1:BYTE_OFS_W];
      end
      if (state != REFILL) begin
        cnt <= '0;
      end else if (mem_rvalid_i) begin
        cnt <= cnt + 2'd1;
      end
      if (fence_i_i) begin
        fence_pending <= 1'b1;
      end else if (fence_clear) begin
        fence_pending <= 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (handshake) next_state = LOOKUP;
        else           next_state = IDLE;
      end
      LOOKUP: begin
        if (hit) next_state = IDLE;
        else     next_state = MISS_REQ;
      end
      MISS_REQ: begin
        if (mem_gnt_i) next_state = REFILL;
        else           next_state = MISS_REQ;
      end
      REFILL: begin
        if (fill_done) next_state = REPLAY;
        else           next_state = REFILL;
      end
      REPLAY:  next_state = LOOKUP;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: the RAM address is combinational from the fetch port while idle so hits take one cycle.
  always_comb begin
    if_ready_o   = 1'b0;
    inst_valid_o = 1'b0;
    inst_o       = ram_data_i;
    ram_addr_o   = {req_index, req_offset};
    ram_we_o     = 1'b0;
    mem_req_o    = 1'b0;
    case (state)
      IDLE: begin
        if_ready_o = ~fence_pending;
        ram_addr_o = if_addr_i[BYTE_OFS_W +: (INDEX_W + OFFSET_W)];
      end
      LOOKUP: begin
        inst_valid_o = hit;
      end
      MISS_REQ: begin
        mem_req_o = 1'b1;
      end
      REFILL: begin
        ram_we_o   = mem_rvalid_i;
        ram_addr_o = {req_index, cnt};
      end
      REPLAY: begin
        ram_addr_o = {req_index, req_offset};
      end
      default: begin
        ram_addr_o = {req_index, req_offset};
      end
    endcase
  end

endmodule
